// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer
// Direct-trace packer and sequencer for the OCI debug block. It packs 2-bit branch
// trace codes into a 30-bit buffer of up to 15 entries. Entry 0 is the oldest code.
// Each packet is {count, buffer} and goes to the trace-memory writer over a
// valid/ready handshake. The block also handles flush requests and the
// end-of-test drain.
//
// Optional feature: define NIOS2_OCI_DCT_DROP_CNT_EN to build a saturating
// counter of codes dropped in RUN. Without it, drop_cnt is tied to zero.
//
// Ports:
//   clk, reset_n    clock; asynchronous active-low reset
//   code_valid/code incoming trace code
//   flush_req       one-cycle pulse; emit the partial buffer
//   test_ending     level; start the end-of-test drain
//   out_valid/out_ready/out_data  packet handshake, data is {count, buffer}
//   dct_buffer/dct_count          live packing buffer and its entry count
//   overflow        sticky; a code was dropped in RUN
//   test_has_ended  sticky; the drain is complete
//   drop_cnt        number of dropped codes (optional feature)
module nios2_oci_dct_packer #(
   parameter int unsigned BUF_W  = 30,
   parameter int unsigned CODE_W = 2,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   code_valid,
   input  logic [CODE_W-1:0]      code,
   input  logic                   flush_req,
   input  logic                   test_ending,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_W+BUF_W-1:0] out_data,
   output logic [BUF_W-1:0]       dct_buffer,
   output logic [CNT_W-1:0]       dct_count,
   output logic                   overflow,
   output logic                   test_has_ended,
   output logic [7:0]             drop_cnt
);

   localparam int unsigned MAX_CNT = BUF_W / CODE_W;
   localparam int unsigned OUT_W   = CNT_W + BUF_W;
   localparam int unsigned SH_W    = $clog2(BUF_W);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ENDING = 2'd1,
      ST_ENDED  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               overflow_q, overflow_d;
   logic               ended_q, ended_d;
   logic               flush_pending_q, flush_pending_d;

   logic               out_free_c;
   logic               full_c;
   logic               emit_c;
   logic               accept_c;
   logic               drop_c;
   logic [BUF_W-1:0]   base_buf_c;
   logic [CNT_W-1:0]   base_cnt_c;
   logic [SH_W-1:0]    shift_c;

   // Next-state logic for packing, output register, flush and drain sequencing
   always_comb begin
      state_d         = state_q;
      buf_d           = buf_q;
      cnt_d           = cnt_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      overflow_d      = overflow_q;
      ended_d         = ended_q;
      flush_pending_d = flush_pending_q;

      out_free_c = !out_valid_q || out_ready;
      full_c     = (cnt_q == CNT_W'(MAX_CNT));
      emit_c     = out_free_c &&
                   (full_c || ((flush_pending_q || state_q == ST_ENDING) && cnt_q != '0));
      // A code that arrives on an emit edge lands in the freshly cleared buffer
      accept_c   = code_valid && (state_q == ST_RUN) && (!full_c || emit_c);
      drop_c     = code_valid && (state_q == ST_RUN) && !accept_c;

      base_buf_c = emit_c ? '0 : buf_q;
      base_cnt_c = emit_c ? '0 : cnt_q;
      shift_c    = SH_W'(CODE_W * base_cnt_c);

      if (emit_c) begin
         out_data_d  = {cnt_q, buf_q};
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      buf_d = base_buf_c;
      cnt_d = base_cnt_c;
      if (accept_c) begin
         buf_d = base_buf_c | (BUF_W'(code) << shift_c);
         cnt_d = base_cnt_c + CNT_W'(1);
      end

      if (drop_c) begin
         overflow_d = 1'b1;
      end

      // A pending flush is retired by its emit or by finding the buffer empty
      if (flush_pending_q) begin
         flush_pending_d = !(emit_c || cnt_q == '0);
      end else begin
         flush_pending_d = flush_req;
      end

      case (state_q)
         ST_RUN: begin
            if (test_ending) begin
               state_d = ST_ENDING;
            end
         end
         ST_ENDING: begin
            if (cnt_q == '0 && !out_valid_q) begin
               state_d = ST_ENDED;
               ended_d = 1'b1;
            end
         end
         ST_ENDED: begin
            ended_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_RUN;
         buf_q           <= '0;
         cnt_q           <= '0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         overflow_q      <= 1'b0;
         ended_q         <= 1'b0;
         flush_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         buf_q           <= buf_d;
         cnt_q           <= cnt_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         overflow_q      <= overflow_d;
         ended_q         <= ended_d;
         flush_pending_q <= flush_pending_d;
      end
   end

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of codes dropped in RUN
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_c && drop_cnt_q != 8'hFF) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'd0;
`endif

   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign overflow       = overflow_q;
   assign test_has_ended = ended_q;

endmodule
